// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
//   Player-input front end for the game control unit. The raw buttons are
//   synchronised with two flops and debounced. A clean single-button press
//   produces a one-cycle fez_jogada pulse and updates the held one-hot jogada
//   code. A multi-button press produces a one-cycle erro_multiplo pulse
//   instead. Every press has to be released, and the release debounced,
//   before another press is accepted.
//
// Ports
//   clock          in   1         system clock, rising edge
//   reset          in   1         synchronous, active-high
//   habilita       in   1         accept new presses
//   limpa          in   1         synchronous clear of jogada
//   botoes         in   N_BOTOES  raw asynchronous buttons, active-high
//   fez_jogada     out  1         one-cycle pulse: valid press captured
//   jogada         out  N_BOTOES  one-hot code of the last valid press
//   erro_multiplo  out  1         one-cycle pulse: several buttons held
//   db_estado      out  3         current FSM state code (debug)
// -----------------------------------------------------------------------------
module detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic                limpa,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                fez_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                erro_multiplo,
    output logic [2:0]          db_estado
);

    localparam int              CW      = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0]   CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0]   CNT_MAX = '1;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        FILTRANDO     = 3'd1,
        PULSO         = 3'd2,
        INVALIDA      = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

    estado_t               state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
    logic [N_BOTOES-1:0]   amostra_reg, amostra_next;
    logic [N_BOTOES-1:0]   jogada_reg, jogada_next;
    logic [N_BOTOES-1:0]   sync1_reg, sync2_reg;
    logic [N_BOTOES-1:0]   botoes_s;
    logic                  armed_reg, armed_next;
    logic                  amostra_one_hot;

    assign botoes_s = sync2_reg;

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign amostra_one_hot = (amostra_reg != '0) &&
                             ((amostra_reg & (amostra_reg - 1'b1)) == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            state_reg   <= OCIOSO;
            cnt_reg     <= '0;
            amostra_reg <= '0;
            jogada_reg  <= '0;
            armed_reg   <= 1'b1;
        end else begin
            sync1_reg   <= botoes;
            sync2_reg   <= sync1_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            amostra_reg <= amostra_next;
            jogada_reg  <= jogada_next;
            armed_reg   <= armed_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        amostra_next = amostra_reg;
        // A capture on PULSO entry below overrides this clear.
        jogada_next  = limpa ? '0 : jogada_reg;

        // armed drops when a press is seen idle while habilita is low, so
        // that press cannot be picked up later when habilita rises; only a
        // return to all-released re-arms the detector.
        armed_next = armed_reg;
        if (botoes_s == '0) begin
            armed_next = 1'b1;
        end else if (state_reg == OCIOSO && !habilita) begin
            armed_next = 1'b0;
        end

        case (state_reg)
            OCIOSO: begin
                cnt_next = '0;
                if (habilita && botoes_s != '0 && armed_reg) begin
                    state_next   = FILTRANDO;
                    amostra_next = botoes_s;
                end
            end
            FILTRANDO: begin
                if (!habilita || botoes_s != amostra_reg) begin
                    state_next = OCIOSO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_FIM) begin
                    if (amostra_one_hot) begin
                        state_next  = PULSO;
                        jogada_next = amostra_reg;
                    end else begin
                        state_next = INVALIDA;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            PULSO, INVALIDA: begin
                state_next = ESPERA_SOLTAR;
                cnt_next   = '0;
            end
            ESPERA_SOLTAR: begin
                if (botoes_s != '0) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_FIM) begin
                    state_next = OCIOSO;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = OCIOSO;
                cnt_next   = '0;
            end
        endcase
    end

    assign fez_jogada    = (state_reg == PULSO);
    assign erro_multiplo = (state_reg == INVALIDA);
    assign jogada        = jogada_reg;
    assign db_estado     = state_reg;

endmodule
